// File: rtl/store_buffer_forward_if.sv
// Store, load-lookup and memory-drain signals of the store buffer, bundled as one port.
// The slave modport is the buffer itself; the master modport is its environment.
interface store_buffer_forward_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              st_valid;
    logic              st_ready;
    logic [5:0]        st_instr_id;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;

    logic              ld_valid;
    logic [5:0]        ld_instr_id;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_fwd_hit;
    logic [31:0]       ld_fwd_data;
    logic              ld_stall;

    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;
    logic [3:0]        mem_wr_strb;

    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    modport slave (
        input  st_valid, st_instr_id, st_addr, st_data,
        input  ld_valid, ld_instr_id, ld_addr,
        input  mem_wr_ready,
        output st_ready, ld_fwd_hit, ld_fwd_data, ld_stall,
        output mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb,
        output count, empty, full
    );

    modport master (
        output st_valid, st_instr_id, st_addr, st_data,
        output ld_valid, ld_instr_id, ld_addr,
        output mem_wr_ready,
        input  st_ready, ld_fwd_hit, ld_fwd_data, ld_stall,
        input  mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb,
        input  count, empty, full
    );
endinterface

// File: rtl/store_buffer_forward.sv
// In-order store buffer draining to memory, with per-byte store-to-load forwarding
// from the registered entries (full hit, miss, or partial-overlap stall).
module store_buffer_forward #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic clk,
    input  logic rst,
    store_buffer_forward_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WORD_W = ADDR_W - 2;

    localparam logic [5:0] INSTR_LB  = 6'd10;
    localparam logic [5:0] INSTR_LH  = 6'd11;
    localparam logic [5:0] INSTR_LW  = 6'd12;
    localparam logic [5:0] INSTR_LBU = 6'd13;
    localparam logic [5:0] INSTR_LHU = 6'd14;
    localparam logic [5:0] INSTR_SB  = 6'd15;
    localparam logic [5:0] INSTR_SH  = 6'd16;
    localparam logic [5:0] INSTR_SW  = 6'd17;

    logic [WORD_W-1:0] e_word [DEPTH];
    logic [31:0]       e_data [DEPTH];
    logic [3:0]        e_strb [DEPTH];
    logic [DEPTH-1:0]  e_valid;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;

    logic              full;
    logic              empty;
    logic              st_ok;
    logic [3:0]        st_strb;
    logic [31:0]       st_lane;
    logic              enq;
    logic              deq;

    logic              ld_ok;
    logic [3:0]        need;
    logic [3:0]        cov;
    logic [31:0]       fwd_word;
    logic [31:0]       shifted;
    logic [31:0]       ext;
    logic [PTR_W-1:0]  idx;
    logic              hit;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    // Misaligned halfword/word stores and non-store ids never enter the buffer.
    always_comb begin
        st_ok   = 1'b0;
        st_strb = 4'b0000;
        case (bus.st_instr_id)
            INSTR_SB: begin
                st_ok   = 1'b1;
                st_strb = 4'b0001 << bus.st_addr[1:0];
            end
            INSTR_SH: begin
                st_ok   = ~bus.st_addr[0];
                st_strb = 4'b0011 << bus.st_addr[1:0];
            end
            INSTR_SW: begin
                st_ok   = (bus.st_addr[1:0] == 2'b00);
                st_strb = 4'b1111;
            end
            default: begin
                st_ok   = 1'b0;
                st_strb = 4'b0000;
            end
        endcase
    end

    assign st_lane = bus.st_data << {bus.st_addr[1:0], 3'b000};
    assign enq     = bus.st_valid && !full && st_ok;
    assign deq     = !empty && bus.mem_wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            e_valid <= '0;
        end else begin
            if (enq) begin
                e_word[wr_ptr]  <= bus.st_addr[ADDR_W-1:2];
                e_data[wr_ptr]  <= st_lane;
                e_strb[wr_ptr]  <= st_strb;
                e_valid[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (deq) begin
                e_valid[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (enq && !deq) begin
                cnt <= cnt + 1'b1;
            end else if (deq && !enq) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        ld_ok = 1'b0;
        need  = 4'b0000;
        case (bus.ld_instr_id)
            INSTR_LB, INSTR_LBU: begin
                ld_ok = 1'b1;
                need  = 4'b0001 << bus.ld_addr[1:0];
            end
            INSTR_LH, INSTR_LHU: begin
                ld_ok = ~bus.ld_addr[0];
                need  = 4'b0011 << bus.ld_addr[1:0];
            end
            INSTR_LW: begin
                ld_ok = (bus.ld_addr[1:0] == 2'b00);
                need  = 4'b1111;
            end
            default: begin
                ld_ok = 1'b0;
                need  = 4'b0000;
            end
        endcase
    end

    // Walk oldest to youngest from the head so a younger matching byte overwrites an older one.
    always_comb begin
        cov      = 4'b0000;
        fwd_word = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (e_valid[idx] && (e_word[idx] == bus.ld_addr[ADDR_W-1:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (e_strb[idx][b]) begin
                        cov[b]           = 1'b1;
                        fwd_word[8*b +: 8] = e_data[idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign shifted = fwd_word >> {bus.ld_addr[1:0], 3'b000};

    always_comb begin
        ext = '0;
        case (bus.ld_instr_id)
            INSTR_LB:  ext = {{24{shifted[7]}}, shifted[7:0]};
            INSTR_LBU: ext = {24'b0, shifted[7:0]};
            INSTR_LH:  ext = {{16{shifted[15]}}, shifted[15:0]};
            INSTR_LHU: ext = {16'b0, shifted[15:0]};
            INSTR_LW:  ext = fwd_word;
            default:   ext = '0;
        endcase
    end

    assign hit = bus.ld_valid && ld_ok && ((cov & need) == need);

    assign bus.ld_fwd_hit   = hit;
    assign bus.ld_stall     = bus.ld_valid && ld_ok && ((cov & need) != 4'b0000) && !hit;
    assign bus.ld_fwd_data  = hit ? ext : 32'h0;

    assign bus.st_ready     = !full;
    assign bus.mem_wr_valid = !empty;
    assign bus.mem_wr_addr  = {e_word[rd_ptr], 2'b00};
    assign bus.mem_wr_data  = e_data[rd_ptr];
    assign bus.mem_wr_strb  = e_strb[rd_ptr];
    assign bus.count        = cnt;
    assign bus.empty        = empty;
    assign bus.full         = full;
endmodule
